// File: rtl/terminal_scheduler.sv
// Round-robin scheduler sharing two output terminals among N_REQ stations,
// with per-terminal occupancy timeout and penalty mask. Optional grant
// statistics outputs are enabled by defining TERM_SCHED_STATS_EN.
module terminal_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             term1_ok,
  input  logic             term2_ok,
  output logic [N_REQ-1:0] gnt1,
  output logic [N_REQ-1:0] gnt2,
  output logic             busy1,
  output logic             busy2,
  output logic             timeout_ev
`ifdef TERM_SCHED_STATS_EN
  ,
  output logic [7:0]       gcnt1,
  output logic [7:0]       gcnt2
`endif
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NT    = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           state_q [NT];
  state_t           state_d [NT];
  logic [N_REQ-1:0] gnt_q   [NT];
  logic [N_REQ-1:0] gnt_d   [NT];
  logic [IDX_W-1:0] idx_q   [NT];
  logic [IDX_W-1:0] idx_d   [NT];
  logic [IDX_W-1:0] ptr_q   [NT];
  logic [IDX_W-1:0] ptr_d   [NT];
  logic [CNT_W-1:0] cnt_q   [NT];
  logic [CNT_W-1:0] cnt_d   [NT];
  logic             busy_q  [NT];
  logic             busy_d  [NT];
  logic             ok      [NT];
  logic [N_REQ-1:0] pen_q;
  logic [N_REQ-1:0] pen_d;
  logic             tev_q;
  logic             tev_d;

  assign ok[0] = term1_ok;
  assign ok[1] = term2_ok;

  // First set bit of elig at or after ptr, wrapping, as a one-hot vector.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] res;
    logic             found;
    int unsigned      pos;
    res   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = (32'(ptr) + off) % N_REQ;
      if (!found && elig[IDX_W'(pos)]) begin
        res[IDX_W'(pos)] = 1'b1;
        found            = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Next-state logic for both terminals; terminal 1 picks before terminal 2.
  always_comb begin
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] claimed;
    logic             owner_req;
    elig      = '0;
    pick      = '0;
    claimed   = '0;
    owner_req = 1'b0;
    tev_d     = 1'b0;
    pen_d     = pen_q & req;
    for (int unsigned k = 0; k < NT; k++) begin
      state_d[k] = state_q[k];
      gnt_d[k]   = gnt_q[k];
      idx_d[k]   = idx_q[k];
      ptr_d[k]   = ptr_q[k];
      cnt_d[k]   = cnt_q[k];
      busy_d[k]  = busy_q[k];
    end
    for (int unsigned k = 0; k < NT; k++) begin
      elig      = req & ~pen_q & ~gnt_q[NT-1-k] & ~claimed;
      owner_req = |(req & gnt_q[k]);
      unique case (state_q[k])
        S_IDLE: begin
          if (ok[k] && (|elig)) begin
            pick       = rr_pick(elig, ptr_q[k]);
            claimed    = claimed | pick;
            state_d[k] = S_BUSY;
            gnt_d[k]   = pick;
            idx_d[k]   = oh_to_idx(pick);
            cnt_d[k]   = CNT_W'(1);
            busy_d[k]  = 1'b1;
          end
        end
        S_BUSY: begin
          if (!owner_req || !ok[k] || (cnt_q[k] == CNT_W'(TIMEOUT))) begin
            state_d[k] = S_RELEASE;
            gnt_d[k]   = '0;
            busy_d[k]  = 1'b0;
            ptr_d[k]   = (idx_q[k] == IDX_W'(N_REQ - 1)) ? '0
                                                         : IDX_W'(idx_q[k] + 1'b1);
            // Penalty only when the owner still wants it and the terminal is up.
            if (owner_req && ok[k]) begin
              tev_d = 1'b1;
              pen_d = pen_d | gnt_q[k];
            end
          end else begin
            cnt_d[k] = CNT_W'(cnt_q[k] + 1'b1);
          end
        end
        S_RELEASE: state_d[k] = S_IDLE;
        default: begin
          state_d[k] = S_IDLE;
          gnt_d[k]   = '0;
          busy_d[k]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NT; k++) begin
        state_q[k] <= S_IDLE;
        gnt_q[k]   <= '0;
        idx_q[k]   <= '0;
        ptr_q[k]   <= '0;
        cnt_q[k]   <= '0;
        busy_q[k]  <= 1'b0;
      end
      pen_q <= '0;
      tev_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NT; k++) begin
        state_q[k] <= state_d[k];
        gnt_q[k]   <= gnt_d[k];
        idx_q[k]   <= idx_d[k];
        ptr_q[k]   <= ptr_d[k];
        cnt_q[k]   <= cnt_d[k];
        busy_q[k]  <= busy_d[k];
      end
      pen_q <= pen_d;
      tev_q <= tev_d;
    end
  end

  assign gnt1       = gnt_q[0];
  assign gnt2       = gnt_q[1];
  assign busy1      = busy_q[0];
  assign busy2      = busy_q[1];
  assign timeout_ev = tev_q;

`ifdef TERM_SCHED_STATS_EN
  logic [7:0] gcnt_q [NT];

  // Saturating count of IDLE->BUSY transitions per terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NT; k++) gcnt_q[k] <= 8'd0;
    end else begin
      for (int unsigned k = 0; k < NT; k++) begin
        if ((state_q[k] == S_IDLE) && (state_d[k] == S_BUSY) && (gcnt_q[k] != 8'hFF))
          gcnt_q[k] <= 8'(gcnt_q[k] + 8'd1);
      end
    end
  end

  assign gcnt1 = gcnt_q[0];
  assign gcnt2 = gcnt_q[1];
`endif

endmodule
